note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Scheduler between the UART receiver and the note decoder/player chain.
- Captures each received byte into a small FIFO and plays queued notes one at a time, each for a fixed duration followed by a silent gap.
- Drives the decoder input and the player enable, so fast Bluetooth input is played as discrete, evenly timed notes.
- Handles two control bytes: flush and rest.

Parameters:
- NOTE_CYCLES, 25_000_000: clk cycles a note (or rest) sounds; 250 ms at 100 MHz; must be >= 1.
- GAP_CYCLES, 2_500_000: silent clk cycles after every slot; must be >= 1.
- FIFO_DEPTH, 8: queue entries; power of 2, >= 2.
- FLUSH_CODE, 8'h1B: byte that clears the queue and stops playback.
- REST_CODE, 8'h2E: byte queued as a silent slot.

Ports:
- clk  in  1  system clock; all registers on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_byte  in  8  received byte from UART receiver; stable while rx_done is high.
- rx_done  in  1  UART frame-complete flag; comes from the baud-derived clock domain.
- note_code  out  8  byte presented to the note decoder.
- audio_en  out  1  1 = player may sound note_code.
- busy  out  1  1 while in PLAY or GAP.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
- overflow  out  1  sticky flag: a byte was dropped because the queue was full.

Behaviour:
- Reset (async, immediate):
  - note_code=0, audio_en=0, busy=0, fifo_count=0, overflow=0.
  - FSM=IDLE, timer=0, sync flops=0, FIFO pointers=0.
- Input capture:
  - rx_done passes through a 2-flop synchronizer (s1, s2) plus a delay flop s3.
  - new_byte = s2 & ~s3, a one-cycle pulse per rising edge of rx_done.
  - rx_byte is sampled in the cycle of new_byte.
  - rx_done held high produces exactly one new_byte.
- Byte classification when new_byte=1:
  - FLUSH_CODE:
    - FIFO cleared (count=0, pointers reset); FSM forced to IDLE; audio_en=0, busy=0, timer=0; overflow cleared.
    - note_code unchanged. The flush byte is not enqueued.
    - Any pop in the same cycle is cancelled.
  - Any other byte, REST_CODE included, is a push:
    - Accepted if count < FIFO_DEPTH, or if count == FIFO_DEPTH and a pop occurs in the same cycle.
    - Otherwise the byte is dropped and overflow is set to 1.
- Count update: push only +1; pop only -1; push and pop together: unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if count > 0, pop the head entry and go to PLAY.
  - PLAY:
    - Entry actions: timer = NOTE_CYCLES-1; note_code = entry; busy=1; audio_en = (entry != REST_CODE).
    - timer decrements each cycle. When timer==0: audio_en=0, timer = GAP_CYCLES-1, go to GAP.
  - GAP:
    - timer decrements each cycle; audio_en=0, busy=1.
    - When timer==0: if count > 0, pop and enter PLAY directly (no IDLE cycle); else go to IDLE with busy=0.
- Timing:
  - audio_en is high for exactly NOTE_CYCLES cycles, then low for exactly GAP_CYCLES cycles, per slot.
  - Back-to-back slot period = NOTE_CYCLES + GAP_CYCLES.
- Latency:
  - rx_done first sampled high at edge k: s2=1 after edge k+1; push written at edge k+2; fifo_count=1 after edge k+2.
  - Pop at edge k+3; note_code, audio_en and busy valid after edge k+3; fifo_count back to 0 after k+3.
- Outputs are all registered; no combinational path from inputs to outputs.
- A pop in the same cycle as a push into an empty FIFO is not possible: the pop needs count > 0 in the previous cycle.
- Reset asserted mid-note silences the output at once; no partial state survives.

Test Plan:
- Use NOTE_CYCLES=10, GAP_CYCLES=3, FIFO_DEPTH=4 unless noted.
- Single note: reset, rx_byte=8'h61 with rx_done pulsed 4 cycles (rise at edge k) -> one push only. fifo_count=1 after k+2. note_code=8'h61 and audio_en=1 after k+3, for 10 cycles. audio_en=0 and busy=1 for 3 cycles, then busy=0, fifo_count=0.
- Back-to-back: push 8'h61, 8'h73, 8'h64 quickly -> three slots with audio_en pattern 10 high / 3 low each. note_code sequence 61, 73, 64. No IDLE cycle between slots. busy continuously 1 for 39 cycles.
- Rest: push 8'h61, 8'h2E, 8'h64 -> second slot has note_code=8'h2E, audio_en=0 for 10 cycles, busy=1. Third note starts exactly 26 cycles after the first.
- Overflow: while playing, push 6 bytes with FIFO_DEPTH=4 -> fifo_count saturates at 4 and overflow=1. Extra bytes are never played. Played order equals the first four pushed.
- Flush mid-note: during PLAY with count=2, push 8'h1B -> 3 cycles after rx_done rise: audio_en=0, busy=0, fifo_count=0, overflow=0, FSM=IDLE. A following 8'h61 plays normally.
- Async reset: assert rst mid-GAP between clock edges -> all outputs 0 immediately, before the next clk edge. After release, a pushed byte plays with the standard 4-edge latency.

Source files
------------

// File: rtl/note_sequencer.sv
// Byte-to-note scheduler: queues received UART bytes and plays them one at a time
// as fixed-length slots followed by a silent gap. Handles flush and rest control bytes.
module note_sequencer #(
    parameter int          NOTE_CYCLES = 25_000_000,
    parameter int          GAP_CYCLES  = 2_500_000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [7:0]  FLUSH_CODE  = 8'h1B,
    parameter logic [7:0]  REST_CODE   = 8'h2E
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_done,
    output logic [7:0]                    note_code,
    output logic                          audio_en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    logic            r_s1, r_s2, r_s3;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_note_code;
    logic            r_audio_en;
    logic            r_busy;

    logic            w_new_byte;
    logic            w_flush;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_slot_end;
    logic [7:0]      w_head;

    // rx_done originates in another clock domain: synchronize, then edge-detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= rx_done;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_new_byte = r_s2 & ~r_s3;
    assign w_flush    = w_new_byte && (rx_byte == FLUSH_CODE);
    assign w_push_req = w_new_byte && (rx_byte != FLUSH_CODE);
    assign w_slot_end = (r_state == S_GAP) && (r_timer == '0);
    assign w_pop      = !w_flush && (r_count != '0) && ((r_state == S_IDLE) || w_slot_end);
    assign w_push     = w_push_req && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // A pop always starts a new slot, whether from IDLE or straight out of GAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_note_code <= 8'h00;
            r_audio_en  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_flush) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_audio_en <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state     <= S_PLAY;
                        r_timer     <= TW'(NOTE_CYCLES - 1);
                        r_note_code <= w_head;
                        r_audio_en  <= (w_head != REST_CODE);
                        r_busy      <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (r_timer == '0) begin
                        r_state    <= S_GAP;
                        r_timer    <= TW'(GAP_CYCLES - 1);
                        r_audio_en <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_pop) begin
                        r_state     <= S_PLAY;
                        r_timer     <= TW'(NOTE_CYCLES - 1);
                        r_note_code <= w_head;
                        r_audio_en  <= (w_head != REST_CODE);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_audio_en <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign note_code  = r_note_code;
    assign audio_en   = r_audio_en;
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: queue-based slot model compared every cycle, directed
// scenarios with literal expectations, then a randomized byte stream.
module tb_note_sequencer;

    localparam int         N  = 10;
    localparam int         G  = 3;
    localparam int         D  = 4;
    localparam logic [7:0] FL = 8'h1B;
    localparam logic [7:0] RS = 8'h2E;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] note_code;
    logic       audio_en;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    always #5 clk = ~clk;

    note_sequencer #(
        .NOTE_CYCLES(N),
        .GAP_CYCLES (G),
        .FIFO_DEPTH (D),
        .FLUSH_CODE (FL),
        .REST_CODE  (RS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_done   (rx_done),
        .note_code (note_code),
        .audio_en  (audio_en),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a queue of pending bytes plus elapsed cycles within the current slot
    logic [7:0] m_q[$];
    bit         m_active = 0;
    int         m_t      = 0;
    logic [7:0] m_note   = 8'h00;
    bit         m_ovf    = 0;
    bit         h1 = 0, h2 = 0, h3 = 0;

    task model_reset();
        m_q.delete();
        m_active = 0;
        m_t      = 0;
        m_note   = 8'h00;
        m_ovf    = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    task model_step();
        bit nb;
        nb = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = rx_done;
        if (nb && rx_byte == FL) begin
            m_q.delete();
            m_active = 0;
            m_ovf    = 0;
        end else begin
            if (!m_active || m_t == N + G - 1) begin
                if (m_q.size() > 0) begin
                    m_note   = m_q.pop_front();
                    m_active = 1;
                    m_t      = 0;
                end else begin
                    m_active = 0;
                end
            end else begin
                m_t++;
            end
            if (nb) begin
                if (m_q.size() < D) m_q.push_back(rx_byte);
                else                m_ovf = 1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            cyc++;
            model_step();
        end
    end

    always @(negedge clk) begin
        chk("note_code",  note_code,  m_note);
        chk("audio_en",   audio_en,   m_active && (m_t < N) && (m_note != RS));
        chk("busy",       busy,       m_active);
        chk("fifo_count", fifo_count, m_q.size());
        chk("overflow",   overflow,   m_ovf);
    end

    // Observed slot history for the directed literal checks
    logic [7:0] played[$];
    int         starts[$];
    bit         pb = 0;
    logic [7:0] pn = 8'h00;
    int         run = 0, last_run = 0, hi_cycles = 0, maxcnt = 0;

    always @(negedge clk) begin
        if (busy && (!pb || note_code != pn)) begin
            played.push_back(note_code);
            starts.push_back(cyc);
        end
        if (busy) run++;
        else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (audio_en) hi_cycles++;
        if (fifo_count > maxcnt) maxcnt = fifo_count;
        pb = busy;
        pn = note_code;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input int h, input int l);
        rx_byte = b;
        rx_done = 1'b1;
        repeat (h) tick();
        rx_done = 1'b0;
        repeat (l) tick();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || fifo_count != 0) && n < 1000) begin
            tick();
            n++;
        end
        chk(name, n < 1000, 1);
    endtask

    task automatic wait_audio(input string name);
        int n = 0;
        while (!audio_en && n < 200) begin
            tick();
            n++;
        end
        chk(name, n < 200, 1);
    endtask

    initial begin
        int hi, g, n;
        logic [7:0] b;
        int r;

        tick();
        chk("rst_note",  note_code,  0);
        chk("rst_audio", audio_en,   0);
        chk("rst_busy",  busy,       0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf",   overflow,   0);
        tick();
        rst = 1'b0;
        tick();

        // Single note: rx_done held 4 cycles, one push, 4-edge latency
        rx_byte = 8'h61;
        rx_done = 1'b1;
        tick(); tick(); tick();
        chk("lat_count_k2", fifo_count, 1);
        chk("lat_audio_k2", audio_en,   0);
        tick();
        chk("lat_note_k3",  note_code,  8'h61);
        chk("lat_audio_k3", audio_en,   1);
        chk("lat_busy_k3",  busy,       1);
        chk("lat_count_k3", fifo_count, 0);
        rx_done = 1'b0;
        hi = 0;
        while (audio_en && hi < 100) begin hi++; tick(); end
        chk("single_high_cycles", hi, N);
        g = 0;
        while (busy && !audio_en && g < 100) begin g++; tick(); end
        chk("single_gap_cycles", g, G);
        chk("single_busy_end",  busy,       0);
        chk("single_count_end", fifo_count, 0);

        // Back-to-back
        tick(); tick();
        played.delete();
        send(8'h61, 1, 2); send(8'h73, 1, 2); send(8'h64, 1, 2);
        wait_idle("b2b_idle_timeout");
        tick();
        chk("b2b_busy_run", last_run, 3 * (N + G));
        chk("b2b_nslots", played.size(), 3);
        if (played.size() == 3) begin
            chk("b2b_note0", played[0], 8'h61);
            chk("b2b_note1", played[1], 8'h73);
            chk("b2b_note2", played[2], 8'h64);
        end

        // Rest slot
        played.delete();
        starts.delete();
        hi_cycles = 0;
        send(8'h61, 1, 2); send(RS, 1, 2); send(8'h64, 1, 2);
        wait_idle("rest_idle_timeout");
        chk("rest_high_total", hi_cycles, 2 * N);
        chk("rest_nslots", played.size(), 3);
        if (starts.size() == 3) begin
            chk("rest_note1",   played[1], RS);
            chk("rest_spacing", starts[2] - starts[0], 2 * (N + G));
        end

        // Overflow: burst while the first note plays
        played.delete();
        maxcnt = 0;
        send(8'h41, 1, 2);
        wait_audio("ovf_audio_timeout");
        for (int i = 0; i < 6; i++) send(8'h50 + 8'(i), 1, 2);
        chk("ovf_flag",   overflow, 1);
        chk("ovf_maxcnt", maxcnt,   D);
        wait_idle("ovf_idle_timeout");
        if (played.size() >= 5) begin
            for (int i = 0; i < 4; i++) chk("ovf_order", played[i + 1], 8'h50 + 8'(i));
        end else begin
            chk("ovf_nslots_min", played.size(), 5);
        end
        n = 0;
        foreach (played[i]) if (played[i] == 8'h55) n++;
        chk("ovf_dropped_never_played", n, 0);

        // Flush mid-note with two entries queued
        send(8'h61, 1, 2); send(8'h73, 1, 2); send(8'h64, 1, 2);
        chk("flush_pre_count", fifo_count, 2);
        chk("flush_pre_note",  note_code,  8'h61);
        chk("flush_pre_audio", audio_en,   1);
        rx_byte = FL;
        rx_done = 1'b1;
        tick(); tick(); tick();
        chk("flush_audio", audio_en,   0);
        chk("flush_busy",  busy,       0);
        chk("flush_count", fifo_count, 0);
        chk("flush_ovf",   overflow,   0);
        chk("flush_note",  note_code,  8'h61);
        rx_done = 1'b0;
        tick(); tick();
        send(8'h62, 1, 2);
        wait_audio("post_flush_timeout");
        chk("post_flush_note", note_code, 8'h62);
        wait_idle("post_flush_idle_timeout");

        // Asynchronous reset in the middle of a gap
        send(8'h61, 1, 2);
        n = 0;
        while (!(busy && !audio_en) && n < 200) begin tick(); n++; end
        chk("gap_wait_timeout", n < 200, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_note",  note_code,  0);
        chk("arst_audio", audio_en,   0);
        chk("arst_busy",  busy,       0);
        chk("arst_count", fifo_count, 0);
        chk("arst_ovf",   overflow,   0);
        tick(); tick();
        rst = 1'b0;
        tick();
        rx_byte = 8'h64;
        rx_done = 1'b1;
        tick(); tick(); tick();
        chk("arst_lat_count", fifo_count, 1);
        tick();
        chk("arst_lat_note",  note_code, 8'h64);
        chk("arst_lat_audio", audio_en,  1);
        rx_done = 1'b0;
        wait_idle("arst_idle_timeout");

        // Randomized stream, checked every cycle against the model
        repeat (150) begin
            r = $urandom_range(0, 99);
            if (r < 15)      b = RS;
            else if (r < 20) b = FL;
            else             b = 8'($urandom_range(0, 255));
            send(b, $urandom_range(1, 4), $urandom_range(2, 12));
        end
        wait_idle("rand_idle_timeout");
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
